rl_pair_scheduler: RTL

RL_PAIR_SCHEDULER -- requirements
Module: rl_pair_scheduler

---
 rtl/rl_pair_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rl_pair_scheduler.sv
// Pair scheduler for the range-limited force pipeline: walks every (home, neighbor)
// pair in row-major order, throttled by downstream stall and an in-flight result budget.
module rl_pair_scheduler #(
    parameter int REF_PARTICLE_NUM        = 100,
    parameter int REF_RAM_ADDR_WIDTH      = 7,
    parameter int NEIGHBOR_PARTICLE_NUM   = 100,
    parameter int NEIGHBOR_RAM_ADDR_WIDTH = 7,
    parameter int MAX_INFLIGHT            = 32,
    parameter int CNT_WIDTH               = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               stall,
    input  logic                               force_valid,
    output logic                               rden,
    output logic [REF_RAM_ADDR_WIDTH-1:0]      home_rdaddr,
    output logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] neighbor_rdaddr,
    output logic                               r2_enable,
    output logic                               busy,
    output logic                               done,
    output logic [CNT_WIDTH-1:0]               issued_cnt,
    output logic [CNT_WIDTH-1:0]               result_cnt,
    output logic [CNT_WIDTH-1:0]               inflight,
    output logic                               error
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int HW = REF_RAM_ADDR_WIDTH;
    localparam int NW = NEIGHBOR_RAM_ADDR_WIDTH;

    state_t          state, next_state;
    logic [HW-1:0]   next_home;
    logic [NW-1:0]   next_nb;
    logic            can_issue;
    logic            last_pair;
    logic            spurious;

    // The pair on the rden output is not yet counted in inflight, so it joins the budget.
    assign can_issue = (state == ISSUE) && !stall &&
                       (({1'b0, inflight} + (CNT_WIDTH+1)'(rden)) < (CNT_WIDTH+1)'(MAX_INFLIGHT));
    assign last_pair = (next_home == HW'(REF_PARTICLE_NUM - 1)) &&
                       (next_nb == NW'(NEIGHBOR_PARTICLE_NUM - 1));
    assign spurious  = force_valid && (inflight == '0) && !rden;

    // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = ISSUE;
            ISSUE:   if (can_issue && last_pair) next_state = DRAIN;
            DRAIN:   if (inflight == '0 && !force_valid && !rden) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: all registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rden            <= 1'b0;
            r2_enable       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            home_rdaddr     <= '0;
            neighbor_rdaddr <= '0;
            next_home       <= '0;
            next_nb         <= '0;
            issued_cnt      <= '0;
            result_cnt      <= '0;
            inflight        <= '0;
        end else begin
            r2_enable <= rden;
            rden      <= can_issue;
            busy      <= (next_state == ISSUE) || (next_state == DRAIN);
            done      <= (next_state == DONE);

            if (can_issue) begin
                home_rdaddr     <= next_home;
                neighbor_rdaddr <= next_nb;
                if (next_nb == NW'(NEIGHBOR_PARTICLE_NUM - 1)) begin
                    next_nb   <= '0;
                    next_home <= next_home + HW'(1);
                end else begin
                    next_nb <= next_nb + NW'(1);
                end
            end

            if (state == DONE) begin
                home_rdaddr     <= '0;
                neighbor_rdaddr <= '0;
            end

            if (state == IDLE) begin
                // Counters and error keep the last run's values until the next start.
                if (start) begin
                    issued_cnt <= '0;
                    result_cnt <= '0;
                    inflight   <= '0;
                    error      <= 1'b0;
                    next_home  <= '0;
                    next_nb    <= '0;
                end
            end else begin
                issued_cnt <= issued_cnt + CNT_WIDTH'(rden);
                result_cnt <= result_cnt + CNT_WIDTH'(force_valid);
                if (spurious)
                    error <= 1'b1;
                else if (rden && !force_valid)
                    inflight <= inflight + CNT_WIDTH'(1);
                else if (!rden && force_valid)
                    inflight <= inflight - CNT_WIDTH'(1);
            end
        end
    end

endmodule
